// File: rtl/pc_fetch_stage_pkg.sv
// Shared fetch-stage definitions: state encoding, NOP encoding, widths and reset PC.
package pc_fetch_stage_pkg;

    localparam int unsigned CPU_XLEN         = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return (pc_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory req/gnt/rvalid port plus the fetch-to-decode valid/ready port.
interface pc_fetch_stage_if;

    logic                                  imem_req_o;
    logic [pc_fetch_stage_pkg::CPU_XLEN-1:0] imem_addr_o;
    logic                                  imem_gnt_i;
    logic                                  imem_rvalid_i;
    logic [pc_fetch_stage_pkg::CPU_XLEN-1:0] imem_rdata_i;
    logic                                  if_valid_o;
    logic [pc_fetch_stage_pkg::CPU_XLEN-1:0] if_instr_o;
    logic [pc_fetch_stage_pkg::CPU_XLEN-1:0] if_pc_o;
    logic                                  if_fault_o;
    logic                                  id_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o, if_fault_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o, if_fault_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
    );

endinterface

// File: rtl/pc_fetch_stage_fetch_out_buf.sv
// Output register for the fetch-to-decode port; holds if_* stable under backpressure.
module pc_fetch_stage_fetch_out_buf
    import pc_fetch_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [CPU_XLEN-1:0] instr_i,
    input  logic [CPU_XLEN-1:0] pc_i,
    input  logic                fault_i,
    input  logic                clear_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [CPU_XLEN-1:0] instr_o,
    output logic [CPU_XLEN-1:0] pc_o,
    output logic                fault_o
);

    logic                valid_q;
    logic [CPU_XLEN-1:0] instr_q;
    logic [CPU_XLEN-1:0] pc_q;
    logic                fault_q;

    // A redirect masks the valid immediately so no transfer can happen that cycle.
    assign valid_o = valid_q & ~clear_i;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign fault_o = fault_q;

    // Output register: clear on redirect, load a new instruction, drop valid on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= {CPU_XLEN{1'b0}};
            pc_q    <= {CPU_XLEN{1'b0}};
            fault_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
            fault_q <= fault_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// PC register and REQ/WAIT/OUT fetch sequencer with stale-response discard after redirects.
// Optional misaligned-fetch fault: define PC_ALIGN_CHECK_EN.
module pc_fetch_stage
    import pc_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned XLEN     = CPU_XLEN
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [XLEN-1:0]    next_pc_i,
    input  logic               redirect_i,
    output logic [XLEN-1:0]    pc_o,
    output logic [XLEN-1:0]    pc_plus4_o,
    pc_fetch_stage_if.master   fetch_if
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic            discard_q;

    logic            misalign_s;
    logic            req_s;
    logic            grant_s;
    logic            buf_load_s;
    logic [XLEN-1:0] buf_instr_s;
    logic            buf_fault_s;

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + 32'd4;

`ifdef PC_ALIGN_CHECK_EN
    assign misalign_s           = is_misaligned(pc_q[1:0]);
    assign fetch_if.imem_addr_o = pc_q;
`else
    assign misalign_s           = 1'b0;
    assign fetch_if.imem_addr_o = {pc_q[XLEN-1:2], 2'b00};
`endif

    assign fetch_if.imem_req_o = req_s;

    // Request qualification and output-buffer load selection.
    always_comb begin
        req_s       = rst_n & (state_q == ST_REQ) & ~misalign_s;
        grant_s     = req_s & fetch_if.imem_gnt_i;
        buf_load_s  = 1'b0;
        buf_instr_s = {XLEN{1'b0}};
        buf_fault_s = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (misalign_s && !redirect_i) begin
                    buf_load_s  = 1'b1;
                    buf_instr_s = NOP_INSTR;
                    buf_fault_s = 1'b1;
                end else begin
                    buf_load_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (fetch_if.imem_rvalid_i && !discard_q && !redirect_i) begin
                    buf_load_s  = 1'b1;
                    buf_instr_s = fetch_if.imem_rdata_i;
                end else begin
                    buf_load_s = 1'b0;
                end
            end
            default: begin
                buf_load_s = 1'b0;
            end
        endcase
    end

    // Fetch FSM: PC update, state sequencing and discard tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (redirect_i) begin
                        pc_q <= next_pc_i;
                        // A grant in the redirect cycle leaves the old request in flight.
                        if (grant_s) begin
                            state_q   <= ST_WAIT;
                            discard_q <= 1'b1;
                        end else begin
                            state_q <= ST_REQ;
                        end
                    end else if (misalign_s) begin
                        state_q <= ST_OUT;
                    end else if (grant_s) begin
                        state_q <= ST_WAIT;
                    end else begin
                        state_q <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (redirect_i) begin
                        pc_q <= next_pc_i;
                    end else begin
                        pc_q <= pc_q;
                    end
                    if (fetch_if.imem_rvalid_i) begin
                        state_q   <= (discard_q || redirect_i) ? ST_REQ : ST_OUT;
                        discard_q <= 1'b0;
                    end else if (redirect_i) begin
                        discard_q <= 1'b1;
                    end else begin
                        discard_q <= discard_q;
                    end
                end
                ST_OUT: begin
                    if (redirect_i || fetch_if.id_ready_i) begin
                        pc_q    <= next_pc_i;
                        state_q <= ST_REQ;
                    end else begin
                        state_q <= ST_OUT;
                    end
                end
                default: begin
                    state_q   <= ST_REQ;
                    discard_q <= 1'b0;
                end
            endcase
        end
    end

    pc_fetch_stage_fetch_out_buf u_fetch_out_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (buf_load_s),
        .instr_i (buf_instr_s),
        .pc_i    (pc_q),
        .fault_i (buf_fault_s),
        .clear_i (redirect_i),
        .ready_i (fetch_if.id_ready_i),
        .valid_o (fetch_if.if_valid_o),
        .instr_o (fetch_if.if_instr_o),
        .pc_o    (fetch_if.if_pc_o),
        .fault_o (fetch_if.if_fault_o)
    );

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed cycle-vector bench for pc_fetch_stage plus a second instance for PC wrap-around.
module tb_pc_fetch_stage;

    typedef struct {
        logic        redir;
        logic [31:0] tgt;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ifpc;
        logic [31:0] e_pc;
        logic        e_fault;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] next_pc = 32'h0;
    logic [31:0] pc, pc_p4;
    logic [31:0] w_next = 32'h0;
    logic [31:0] w_pc, w_p4;
    int          n_checks = 0;
    int          n_errors = 0;
    vec_t        tbl[21];

    pc_fetch_stage_if d_if();
    pc_fetch_stage_if w_if();

    pc_fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .next_pc_i(next_pc), .redirect_i(redirect),
        .pc_o(pc), .pc_plus4_o(pc_p4), .fetch_if(d_if)
    );

    pc_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .next_pc_i(w_next), .redirect_i(1'b0),
        .pc_o(w_pc), .pc_plus4_o(w_p4), .fetch_if(w_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs after the falling edge, then check outputs before the rising edge.
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        redirect            = v.redir;
        next_pc             = v.redir ? v.tgt : (v.e_pc + 32'd4);
        d_if.imem_gnt_i     = v.gnt;
        d_if.imem_rvalid_i  = v.rvalid;
        d_if.imem_rdata_i   = v.rdata;
        d_if.id_ready_i     = v.ready;
        #1;
        chk({tag, ".req"}, {31'd0, d_if.imem_req_o}, {31'd0, v.e_req});
        if (v.e_req) chk({tag, ".addr"}, d_if.imem_addr_o, v.e_addr);
        chk({tag, ".valid"}, {31'd0, d_if.if_valid_o}, {31'd0, v.e_valid});
        if (v.e_valid) begin
            chk({tag, ".instr"}, d_if.if_instr_o, v.e_instr);
            chk({tag, ".ifpc"}, d_if.if_pc_o, v.e_ifpc);
        end
        chk({tag, ".pc"}, pc, v.e_pc);
        chk({tag, ".pc4"}, pc_p4, v.e_pc + 32'd4);
        chk({tag, ".fault"}, {31'd0, d_if.if_fault_o}, {31'd0, v.e_fault});
    endtask

    initial begin
        // redir tgt gnt rvalid rdata ready | req addr valid instr ifpc pc fault
        tbl[0]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0,       32'h0,  32'h00, 1'b0};
        tbl[1]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0000, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0,  32'h00, 1'b0};
        tbl[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,         1'b1, 32'hA000_0000, 32'h0, 32'h00, 1'b0};
        tbl[3]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0,       32'h0,  32'h04, 1'b0};
        tbl[4]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0004, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0,  32'h04, 1'b0};
        tbl[5]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,         1'b1, 32'hA000_0004, 32'h4, 32'h04, 1'b0};
        tbl[6]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0008, 1'b0, 32'h0,       32'h0,  32'h08, 1'b0};
        tbl[7]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0008, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0,  32'h08, 1'b0};
        tbl[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,         1'b1, 32'hA000_0008, 32'h8, 32'h08, 1'b0};
        tbl[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0,       32'h0,  32'h0C, 1'b0};
        tbl[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_000C, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0,  32'h0C, 1'b0};
        tbl[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,         1'b1, 32'hA000_000C, 32'hC, 32'h0C, 1'b0};
        tbl[12] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0010, 1'b0, 32'h0,       32'h0,  32'h10, 1'b0};
        tbl[13] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0010, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0,  32'h10, 1'b0};
        for (int k = 14; k < 19; k++)
            tbl[k] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_0010, 32'h10, 32'h10, 1'b0};
        tbl[19] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,         1'b1, 32'hA000_0010, 32'h10, 32'h10, 1'b0};
        tbl[20] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0014, 1'b0, 32'h0,       32'h0,  32'h14, 1'b0};

        d_if.imem_gnt_i = 1'b0; d_if.imem_rvalid_i = 1'b0; d_if.imem_rdata_i = 32'h0; d_if.id_ready_i = 1'b0;
        w_if.imem_gnt_i = 1'b0; w_if.imem_rvalid_i = 1'b0; w_if.imem_rdata_i = 32'h0; w_if.id_ready_i = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst.req", {31'd0, d_if.imem_req_o}, 32'd0);
        chk("rst.valid", {31'd0, d_if.if_valid_o}, 32'd0);
        chk("rst.instr", d_if.if_instr_o, 32'h0);
        chk("rst.ifpc", d_if.if_pc_o, 32'h0);
        chk("rst.fault", {31'd0, d_if.if_fault_o}, 32'd0);
        chk("rst.pc", pc, 32'h0);
        chk("rst.wpc", w_pc, 32'hFFFF_FFFC);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Redirect while waiting: late response 0xDEADBEEF must never reach decode.
        step('{1'b1, 32'h20,  1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h14,  1'b0, 32'h0, 32'h0, 32'h14,  1'b0}, "rw0");
        step('{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h20,  1'b0, 32'h0, 32'h0, 32'h20,  1'b0}, "rw1");
        step('{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 32'h20,  1'b0}, "rw2");
        step('{1'b0, 32'h0,   1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 32'h100, 1'b0}, "rw3");
        step('{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 32'h100, 1'b0}, "rw4");
        step('{1'b0, 32'h0,   1'b0, 1'b1, 32'hB000_0100, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 32'h100, 1'b0}, "rw5");
        step('{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'hB000_0100, 32'h100, 32'h100, 1'b0}, "rw6");

        // Redirect coincident with grant at 0x40, then redirect coincident with id_ready in OUT.
        step('{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h104, 1'b0, 32'h0, 32'h0, 32'h104, 1'b0}, "rg0");
        step('{1'b1, 32'h80,  1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h40,  1'b0, 32'h0, 32'h0, 32'h40,  1'b0}, "rg1");
        step('{1'b0, 32'h0,   1'b0, 1'b1, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 32'h80,  1'b0}, "rg2");
        step('{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h80,  1'b0, 32'h0, 32'h0, 32'h80,  1'b0}, "rg3");
        step('{1'b0, 32'h0,   1'b0, 1'b1, 32'hC000_0080, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 32'h80,  1'b0}, "rg4");
        step('{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'hC000_0080, 32'h80, 32'h80, 1'b0}, "rg5");
        step('{1'b1, 32'h200, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 32'h80,  1'b0}, "ro0");
        step('{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 32'h200, 1'b0}, "ro1");

        // Redirect in the same cycle as rvalid: response dropped, fetch restarts at target.
        step('{1'b1, 32'h300, 1'b0, 1'b1, 32'h7777_7777, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 32'h200, 1'b0}, "rv0");
        step('{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 32'h0, 32'h300, 1'b0}, "rv1");
        step('{1'b0, 32'h0,   1'b0, 1'b1, 32'hD000_0300, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 32'h300, 1'b0}, "rv2");
        step('{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'hD000_0300, 32'h300, 32'h300, 1'b0}, "rv3");

        // Misaligned redirect target 0x102.
        step('{1'b1, 32'h102, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h304, 1'b0, 32'h0, 32'h0, 32'h304, 1'b0}, "ma0");
`ifdef PC_ALIGN_CHECK_EN
        step('{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 32'h102, 1'b0}, "ma1");
        step('{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h0000_0013, 32'h102, 32'h102, 1'b1}, "ma2");
        step('{1'b1, 32'h200, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 32'h102, 1'b1}, "ma3");
        step('{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 32'h200, 1'b0}, "ma4");
`else
        step('{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 32'h102, 1'b0}, "ma1");
        step('{1'b0, 32'h0,   1'b0, 1'b1, 32'hE000_0102, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 32'h102, 1'b0}, "ma2");
        step('{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'hE000_0102, 32'h102, 32'h102, 1'b0}, "ma3");
        step('{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h104, 1'b0, 32'h0, 32'h0, 32'h106, 1'b0}, "ma4");
`endif

        // Wrap instance: one transfer from 0xFFFF_FFFC lands on PC 0.
        @(negedge clk);
        #1;
        chk("wrap.pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap.pc4", w_p4, 32'h0000_0000);
        chk("wrap.req", {31'd0, w_if.imem_req_o}, 32'd1);
        chk("wrap.addr", w_if.imem_addr_o, 32'hFFFF_FFFC);
        w_if.imem_gnt_i = 1'b1;
        @(negedge clk);
        w_if.imem_gnt_i = 1'b0; w_if.imem_rvalid_i = 1'b1; w_if.imem_rdata_i = 32'hF00D_0001;
        #1;
        chk("wrap.wait_req", {31'd0, w_if.imem_req_o}, 32'd0);
        @(negedge clk);
        w_if.imem_rvalid_i = 1'b0; w_if.id_ready_i = 1'b1; w_next = 32'h0000_0000;
        #1;
        chk("wrap.valid", {31'd0, w_if.if_valid_o}, 32'd1);
        chk("wrap.ifpc", w_if.if_pc_o, 32'hFFFF_FFFC);
        chk("wrap.instr", w_if.if_instr_o, 32'hF00D_0001);
        @(negedge clk);
        w_if.id_ready_i = 1'b0;
        #1;
        chk("wrap.pc_after", w_pc, 32'h0000_0000);
        chk("wrap.addr_after", w_if.imem_addr_o, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
